// File: rtl/blit_pkg.sv
// Shared widths and state encoding for the blitter glyph row address generator.
// Optional glyph bounds checking is enabled by defining BLIT_GLYPH_BOUNDS_EN.
package blit_pkg;

  localparam int ADDR_W = 26;
  localparam int CHAR_W = 8;
  localparam int BPC_W  = 8;
  localparam int ROWS_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    EMIT = 2'd2
  } blit_glyph_state_t;

endpackage

// File: rtl/blit_glyph_row_addr_if.sv
// Command and row-address stream bundle between the command decoder, the address
// generator and the source-fetch stage. BLIT_GLYPH_BOUNDS_EN adds the bounds-check signals.
interface blit_glyph_row_addr_if;
  import blit_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src_addr;
  logic [CHAR_W-1:0] cmd_char;
  logic [BPC_W-1:0]  cmd_font_bpc;
  logic [BPC_W-1:0]  cmd_row_bytes;
  logic [ROWS_W-1:0] cmd_rows;
  logic              cmd_textmode;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
`ifdef BLIT_GLYPH_BOUNDS_EN
  logic [CHAR_W-1:0] cmd_font_nchars;
  logic              out_err;
`endif

  modport master (
`ifdef BLIT_GLYPH_BOUNDS_EN
    output cmd_font_nchars,
    input  out_err,
`endif
    output cmd_valid, cmd_src_addr, cmd_char, cmd_font_bpc, cmd_row_bytes, cmd_rows, cmd_textmode,
    input  cmd_ready,
    input  out_valid, out_addr, out_last,
    output out_ready
  );

  modport slave (
`ifdef BLIT_GLYPH_BOUNDS_EN
    input  cmd_font_nchars,
    output out_err,
`endif
    input  cmd_valid, cmd_src_addr, cmd_char, cmd_font_bpc, cmd_row_bytes, cmd_rows, cmd_textmode,
    output cmd_ready,
    output out_valid, out_addr, out_last,
    input  out_ready
  );

endinterface

// File: rtl/blit_glyph_mul.sv
// Registered glyph base computation: base = src_addr + zext(char_code * bpc), modulo 2^ADDR_W.
module blit_glyph_mul
  import blit_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [CHAR_W-1:0] char_code,
  input  logic [BPC_W-1:0]  bpc,
  output logic [ADDR_W-1:0] base
);

  localparam int PROD_W = CHAR_W + BPC_W;

  logic [PROD_W-1:0] product;
  logic [ADDR_W-1:0] product_ext;
  logic [ADDR_W-1:0] base_reg;

  assign product = PROD_W'(char_code) * PROD_W'(bpc);

  generate
    if (PROD_W < ADDR_W) begin : g_zext
      assign product_ext = {{(ADDR_W - PROD_W){1'b0}}, product};
    end else begin : g_trunc
      assign product_ext = product[ADDR_W-1:0];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_reg <= '0;
    end else if (load) begin
      base_reg <= src_addr + product_ext;
    end
  end

  assign base = base_reg;

endmodule

// File: rtl/blit_glyph_row_addr.sv
// Per-row source address generator for blitter text mode; non-text commands pass through as
// a single beat. Define BLIT_GLYPH_BOUNDS_EN to add character-range checking with out_err.
module blit_glyph_row_addr
  import blit_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  blit_glyph_row_addr_if.slave  bus,
  output logic                  busy
);

  blit_glyph_state_t state_reg, state_next;

  logic              out_valid_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic              out_last_reg;
  logic [ROWS_W-1:0] row_idx_reg;
  logic [ROWS_W-1:0] rows_reg;
  logic [BPC_W-1:0]  row_bytes_reg;
  logic              err_reg;

  logic              cmd_fire;
  logic              out_fire;
  logic              char_oob;
  logic [CHAR_W-1:0] char_eff;
  logic [ADDR_W-1:0] glyph_base;
  logic [ROWS_W:0]   next_idx_plus1;

  assign cmd_fire = bus.cmd_valid && (state_reg == IDLE);
  assign out_fire = out_valid_reg && bus.out_ready;

`ifdef BLIT_GLYPH_BOUNDS_EN
  // A zero glyph count means the font size is unknown, so nothing is flagged.
  assign char_oob = (bus.cmd_font_nchars != '0) && (bus.cmd_char >= bus.cmd_font_nchars);
  assign char_eff = char_oob ? '0 : bus.cmd_char;
  assign bus.out_err = err_reg;
`else
  assign char_oob = 1'b0;
  assign char_eff = bus.cmd_char;
`endif

  blit_glyph_mul u_mul (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (cmd_fire && bus.cmd_textmode),
    .src_addr  (bus.cmd_src_addr),
    .char_code (char_eff),
    .bpc       (bus.cmd_font_bpc),
    .base      (glyph_base)
  );

  // Index of the beat that follows the one being accepted, plus one; equals rows on the last.
  assign next_idx_plus1 = (ROWS_W + 1)'(row_idx_reg) + (ROWS_W + 1)'(2);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.cmd_valid) state_next = bus.cmd_textmode ? MULT : EMIT;
      MULT: state_next = (rows_reg == '0) ? IDLE : EMIT;
      EMIT: if (out_fire && out_last_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_last_reg  <= 1'b0;
      row_idx_reg   <= '0;
      rows_reg      <= '0;
      row_bytes_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            rows_reg      <= bus.cmd_rows;
            row_bytes_reg <= bus.cmd_row_bytes;
            row_idx_reg   <= '0;
            err_reg       <= bus.cmd_textmode && char_oob;
            if (!bus.cmd_textmode) begin
              out_valid_reg <= 1'b1;
              out_addr_reg  <= bus.cmd_src_addr;
              out_last_reg  <= 1'b1;
            end
          end
        end
        MULT: begin
          row_idx_reg <= '0;
          if (rows_reg != '0) begin
            out_valid_reg <= 1'b1;
            out_addr_reg  <= glyph_base;
            out_last_reg  <= (rows_reg == ROWS_W'(1));
          end else begin
            err_reg <= 1'b0;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (out_last_reg) begin
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              err_reg       <= 1'b0;
            end else begin
              out_addr_reg <= out_addr_reg + ADDR_W'(row_bytes_reg);
              row_idx_reg  <= row_idx_reg + ROWS_W'(1);
              out_last_reg <= (next_idx_plus1 == (ROWS_W + 1)'(rows_reg));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_addr  = out_addr_reg;
  assign bus.out_last  = out_last_reg;
  assign busy          = (state_reg != IDLE);

endmodule
